uart_rx_sampler: RTL and testbench



---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx_sampler.sv | 143 ++++++++++++++
 tb/tb_uart_rx_sampler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle between the serial pad and the byte consumer.
// The sampler is the slave and the consumer is the master.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 serial_in;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 overrun_error;
    logic                 framing_error;

    modport master (
        output serial_in,
        output data_read,
        input  rx_data,
        input  data_ready,
        input  overrun_error,
        input  framing_error
    );

    modport slave (
        input  serial_in,
        input  data_read,
        output rx_data,
        output data_ready,
        output overrun_error,
        output framing_error
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front-end: start detect, mid-bit sampling, LSB-first shift-in,
// stop-bit check and a level-valid / read-acknowledge word output.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input logic     clk,
    input logic     n_rst,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     idx_cnt_q, idx_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 ready_q, ready_d;
    logic                 ovr_q, ovr_d;
    logic                 fe_q, fe_d;
    logic                 s_in;

    assign s_in = sync2_q;

    always_comb begin
        sync1_d   = bus.serial_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_cnt_d = idx_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        fe_d      = fe_q;

        if (state_q != IDLE) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end

        if (bus.data_read && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!s_in) begin
                    state_d   = START_CHK;
                    bit_cnt_d = '0;
                    idx_cnt_d = '0;
                end
            end
            START_CHK: begin
                if (bit_cnt_q == HALF_M1) begin
                    bit_cnt_d = '0;
                    if (s_in) begin
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    shift_d = {s_in, shift_q[DATA_BITS-1:1]};
                    if (idx_cnt_q == IDX_LAST) begin
                        idx_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        idx_cnt_d = idx_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    if (s_in) begin
                        state_d = LOAD;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LOAD: begin
                // a read landing in this cycle is absorbed by the new word
                rx_data_d = shift_q;
                ready_d   = 1'b1;
                if (ready_q && !bus.data_read) begin
                    ovr_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            bit_cnt_q <= '0;
            idx_cnt_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            bit_cnt_q <= bit_cnt_d;
            idx_cnt_q <= idx_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.data_ready    = ready_q;
    assign bus.overrun_error = ovr_q;
    assign bus.framing_error = fe_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frame-timing reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_sampler;
    localparam int C = 10;
    localparam int D = 8;
    localparam int H = C / 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    uart_rx_if #(.DATA_BITS(D)) bus_i ();

    uart_rx_sampler #(
        .CLKS_PER_BIT(C),
        .DATA_BITS(D)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus_i)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int printed = 0;

    // reference model state
    int cyc = 0;
    int first_edge = 1;
    bit line_h [65536];
    bit m_act = 0;
    int t0 = 0;
    int load_at = -1;
    int free_at = 0;
    logic [D-1:0] m_word = '0;
    logic [D-1:0] m_rx = '0;
    bit m_rdy = 0;
    bit m_ovr = 0;
    bit m_fe = 0;
    int mn, off, k;
    bit s, rd;

    bit done = 0;
    bit rnd_rd = 0;
    int rise_cyc = -1;
    int rise_cnt = 0;
    int last_l = 0;

    // Line value seen by the frame logic at edge n is the pad value at edge n-2.
    initial forever begin
        @(posedge clk or negedge n_rst);
        if (!n_rst) begin
            m_act = 0;
            load_at = -1;
            free_at = 0;
            m_word = '0;
            m_rx = '0;
            m_rdy = 0;
            m_ovr = 0;
            m_fe = 0;
            first_edge = cyc + 1;
        end else begin
            cyc++;
            mn = cyc;
            line_h[mn] = bus_i.serial_in;
            s = (mn - 2 >= first_edge) ? line_h[mn-2] : 1'b1;
            rd = bus_i.data_read && m_rdy;
            if (mn == load_at) begin
                if (m_rdy && !bus_i.data_read) m_ovr = 1;
                else if (rd) m_ovr = 0;
                m_rx = m_word;
                m_rdy = 1;
                load_at = -1;
                free_at = mn + 1;
            end else if (rd) begin
                m_rdy = 0;
                m_ovr = 0;
            end
            if (m_act) begin
                off = mn - t0;
                if (off == H) begin
                    if (s) begin
                        m_act = 0;
                        free_at = mn + 1;
                    end else begin
                        m_fe = 0;
                    end
                end else if (off > H && (off - H) % C == 0) begin
                    k = (off - H) / C - 1;
                    if (k < D) begin
                        m_word[k] = s;
                    end else begin
                        m_act = 0;
                        if (s) begin
                            load_at = mn + 1;
                        end else begin
                            m_fe = 1;
                            free_at = mn + 1;
                        end
                    end
                end
            end else if (load_at < 0 && mn >= free_at && !s) begin
                m_act = 1;
                t0 = mn;
            end
        end
    end

    logic prev_rdy = 0;

    initial begin
        while (!done) begin
            @(negedge clk);
            total++;
            if ({bus_i.rx_data, bus_i.data_ready, bus_i.overrun_error,
                 bus_i.framing_error} === {m_rx, m_rdy, m_ovr, m_fe}) begin
                passed++;
            end else if (printed < 20) begin
                printed++;
                $display("FAIL model cycle %0d: got rx=%h rdy=%b ovr=%b fe=%b, need rx=%h rdy=%b ovr=%b fe=%b",
                         cyc, bus_i.rx_data, bus_i.data_ready, bus_i.overrun_error,
                         bus_i.framing_error, m_rx, m_rdy, m_ovr, m_fe);
            end
            if (bus_i.data_ready === 1'b1 && !prev_rdy) begin
                rise_cyc = cyc;
                rise_cnt++;
            end
            prev_rdy = (bus_i.data_ready === 1'b1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic rnd_read();
        return rnd_rd && ($urandom % 16 == 0);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_i.serial_in = 1'b1;
            bus_i.data_read = rnd_read();
        end
    endtask

    task automatic send(input logic [D-1:0] d, input bit stop, input int rd_at, input int gap);
        for (int j = 0; j < (D + 2) * C; j++) begin
            @(negedge clk);
            if (j == 0) last_l = cyc + 1;
            if (j < C) bus_i.serial_in = 1'b0;
            else if (j < (D + 1) * C) bus_i.serial_in = d[j/C-1];
            else bus_i.serial_in = stop;
            bus_i.data_read = (j == rd_at) || rnd_read();
        end
        idle(gap);
    endtask

    task automatic glitch(input int len, input int gap);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            bus_i.serial_in = 1'b0;
            bus_i.data_read = rnd_read();
        end
        idle(gap);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        bus_i.data_read = 1'b1;
        @(negedge clk);
        bus_i.data_read = 1'b0;
    endtask

    initial begin
        int rc;
        bus_i.serial_in = 1'b1;
        bus_i.data_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx", int'(bus_i.rx_data), 0);
        chk("reset_rdy", int'(bus_i.data_ready), 0);
        chk("reset_ovr", int'(bus_i.overrun_error), 0);
        chk("reset_fe", int'(bus_i.framing_error), 0);
        n_rst = 1'b1;
        idle(20);

        send(8'hA5, 1'b1, -1, 10);
        chk("nominal_latency", rise_cyc - last_l, 98);
        chk("nominal_rx", int'(bus_i.rx_data), 'hA5);
        chk("nominal_rdy", int'(bus_i.data_ready), 1);
        chk("nominal_ovr", int'(bus_i.overrun_error), 0);
        chk("nominal_fe", int'(bus_i.framing_error), 0);
        pulse_read();
        chk("read_clears_rdy", int'(bus_i.data_ready), 0);

        glitch(3, 30);
        chk("glitch_rdy", int'(bus_i.data_ready), 0);
        chk("glitch_fe", int'(bus_i.framing_error), 0);

        send(8'h3C, 1'b0, -1, 20);
        chk("frame_err_fe", int'(bus_i.framing_error), 1);
        chk("frame_err_rdy", int'(bus_i.data_ready), 0);
        chk("frame_err_rx", int'(bus_i.rx_data), 'hA5);
        send(8'h81, 1'b1, -1, 20);
        chk("recover_fe", int'(bus_i.framing_error), 0);
        chk("recover_rx", int'(bus_i.rx_data), 'h81);
        pulse_read();

        send(8'h11, 1'b1, -1, 0);
        send(8'h22, 1'b1, -1, 10);
        chk("overrun_rx", int'(bus_i.rx_data), 'h22);
        chk("overrun_rdy", int'(bus_i.data_ready), 1);
        chk("overrun_ovr", int'(bus_i.overrun_error), 1);
        pulse_read();
        chk("overrun_clr_rdy", int'(bus_i.data_ready), 0);
        chk("overrun_clr_ovr", int'(bus_i.overrun_error), 0);

        send(8'h11, 1'b1, -1, 0);
        send(8'h22, 1'b1, 97, 10);
        chk("coincide_rdy", int'(bus_i.data_ready), 1);
        chk("coincide_ovr", int'(bus_i.overrun_error), 0);
        chk("coincide_rx", int'(bus_i.rx_data), 'h22);

        @(negedge clk);
        bus_i.serial_in = 1'b0;
        repeat (30) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_rx", int'(bus_i.rx_data), 0);
        chk("async_rst_rdy", int'(bus_i.data_ready), 0);
        chk("async_rst_ovr", int'(bus_i.overrun_error), 0);
        chk("async_rst_fe", int'(bus_i.framing_error), 0);
        bus_i.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        rc = rise_cnt;
        idle(200);
        chk("post_rst_quiet", rise_cnt - rc, 0);

        rnd_rd = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 6 == 0) begin
                glitch(1 + int'($urandom % 8), 5 + int'($urandom % 20));
            end else begin
                send(D'($urandom), ($urandom % 8) != 0,
                     ($urandom % 4 == 0) ? 97 : -1, int'($urandom % 25));
            end
        end
        rnd_rd = 0;
        idle(30);

        done = 1;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
